inst_refill_bridge: RTL and testbench
=====================================

Name: inst_refill_bridge

Overview:
- Responder end of the instruction-cache miss interface. Accepts a miss request (req/addr) from the instruction cache and performs a single-word read on the SRAM-like memory port (req/addr_ok/data_ok).
- Returns the fetched word with a one-cycle done strobe, which the cache uses as its line write enable.
- Sits between the instruction cache and the memory arbiter.
- Discards stale returns when the cache's request is withdrawn or its address changes mid-flight.

Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit in cycles for one memory transaction. Used only with INST_REFILL_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- resetn  in  1  synchronous, active-low reset.
- inst_cache_req  in  1  miss request from the cache; level, held while the miss is outstanding.
- inst_cache_addr  in  32  miss address; word aligned.
- inst_cache_rdata  out  32  fetched word, registered; holds its value until the next completion.
- inst_cache_dok  out  1  one-cycle done strobe, aligned with valid inst_cache_rdata.
- inst_cache_err  out  1  one-cycle timeout strobe. Tied 0 without the macro.
- mem_req  out  1  memory read request; held until mem_addr_ok.
- mem_addr  out  32  registered copy of the latched miss address.
- mem_addr_ok  in  1  address accepted, sampled while mem_req=1.
- mem_data_ok  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (resetn=0 at a clk edge) puts all outputs at zero: state=IDLE, mem_req=0, mem_addr=0, inst_cache_rdata=0, inst_cache_dok=0, inst_cache_err=0. Reset mid-transaction abandons it; any later mem_data_ok is ignored while in IDLE.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE, inst_cache_req=1: latch inst_cache_addr into addr_q and go to ADDR. mem_req = (state==ADDR); mem_addr = addr_q.
- ADDR: hold mem_req and mem_addr stable. On mem_addr_ok=1 go to DATA. The request is never withdrawn in ADDR, even if inst_cache_req falls.
- DATA: wait for mem_data_ok. When it arrives:
  - If inst_cache_req=1 and inst_cache_addr==addr_q: capture mem_rdata into inst_cache_rdata and go to DONE.
  - Otherwise (stale): drop the data, go to IDLE, dok stays 0.
- DONE: inst_cache_dok=1 for exactly this one cycle. Next state is IDLE unconditionally; no new request is sampled in DONE, because the cache's hit is valid only after its write.
- mem_data_ok outside DATA is ignored.
- Minimum latency: req sampled at cycle 0, mem_req high at cycle 1, addr_ok at cycle 1, data_ok at cycle 2, dok at cycle 3.
- Exactly one transaction is outstanding at any time.
- Back-to-back misses: the second req is sampled in the IDLE cycle after DONE.
- mem_addr_ok and mem_data_ok in the same cycle while in ADDR: treat addr_ok only. data_ok must come in a later cycle, and the memory side guarantees this.

Optional Feature:
- INST_REFILL_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entry to ADDR and increments each cycle in ADDR or DATA.
  - When count reaches TIMEOUT_CYCLES: inst_cache_rdata is set to 0, inst_cache_err pulses for 1 cycle, inst_cache_dok stays 0, and the FSM goes to IDLE.
  - If the timeout fires in ADDR, mem_req drops.
- Undefined: no counter; inst_cache_err is constant 0; the FSM waits indefinitely.

Test Plan:
- Basic fetch: req=1, addr=0xBFC00000, addr_ok at cycle 1, data_ok+rdata=0x3C08BFC0 at cycle 2. Expect mem_req=1 at cycle 1 only, mem_addr=0xBFC00000, dok=1 at cycle 3 only, rdata=0x3C08BFC0 held afterwards.
- Memory wait states: addr_ok delayed 3 cycles, data_ok 4 cycles after that. Expect mem_req high for 4 cycles with mem_addr stable, a single dok, and correct data.
- Stale return: req at 0x1000, then addr changes to 0x2000 while in DATA. Expect data_ok dropped, no dok, and the next IDLE issuing mem_addr=0x2000.
- Reset mid-flight: resetn=0 while in DATA, then data_ok arrives after release. Expect all outputs 0 and no dok.
- Back-to-back misses at 0x0, 0x4. Expect exactly two dok pulses, separated by at least one IDLE cycle.
- Timeout (macro defined, TIMEOUT_CYCLES=8): addr_ok is never given. Expect mem_req to drop after 8 cycles, err=1 for 1 cycle, dok=0.

Source files
------------

// File: rtl/inst_refill_bridge.sv
// ---------------------------------------------------------------------------
// inst_refill_bridge
//   Responder end of the instruction-cache miss interface. Each miss becomes
//   one single-word read on the SRAM-like memory port, and the word goes back
//   to the cache with a one-cycle done strobe (the cache's line write enable).
//   Returns whose request was withdrawn or re-addressed mid-flight are dropped.
//
// Optional feature (macro INST_REFILL_TIMEOUT_EN):
//   Adds a watchdog counter. When a memory transaction runs for
//   TIMEOUT_CYCLES cycles it is abandoned: rdata is cleared, err pulses and
//   the FSM returns to IDLE. Without the macro err is constant 0 and the FSM
//   waits indefinitely.
//
// Ports:
//   clk              rising-edge clock
//   resetn           synchronous active-low reset
//   inst_cache_req   miss request (level, held while outstanding)
//   inst_cache_addr  miss address (word aligned)
//   inst_cache_rdata fetched word, registered, held until next completion
//   inst_cache_dok   one-cycle done strobe aligned with valid rdata
//   inst_cache_err   one-cycle timeout strobe
//   mem_req          memory read request, held until mem_addr_ok
//   mem_addr         latched miss address
//   mem_addr_ok      address accepted
//   mem_data_ok      read data valid
//   mem_rdata        read data
// ---------------------------------------------------------------------------
module inst_refill_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_cache_req,
  input  logic [31:0] inst_cache_addr,
  output logic [31:0] inst_cache_rdata,
  output logic        inst_cache_dok,
  output logic        inst_cache_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] rdata_r;
  logic        mem_req_r;
  logic        dok_r;
  logic        err_r;
  logic        hit_s;
  logic        timeout_s;

  // A return is only delivered if the cache still wants this very address.
  assign hit_s = inst_cache_req && (inst_cache_addr == addr_r);

`ifdef INST_REFILL_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
  // Counter holds cycles already spent; firing at LIMIT-1 means the
  // transaction has used exactly TIMEOUT_CYCLES cycles in ADDR/DATA.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  assign timeout_s = ((state_r == ADDR) || (state_r == DATA)) && (cnt_r == CNT_LAST);

  // Watchdog counter: cleared on entry to ADDR, counts while in ADDR/DATA.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == IDLE) && inst_cache_req) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ADDR) || (state_r == DATA)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  logic unused_timeout_cfg_s;

  assign timeout_s            = 1'b0;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

  // Refill FSM with registered memory-side and cache-side outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      addr_r    <= 32'd0;
      rdata_r   <= 32'd0;
      mem_req_r <= 1'b0;
      dok_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      dok_r <= 1'b0;
      err_r <= timeout_s;
      if (timeout_s) begin
        state_r   <= IDLE;
        mem_req_r <= 1'b0;
        rdata_r   <= 32'd0;
      end else begin
        case (state_r)
          IDLE: begin
            if (inst_cache_req) begin
              addr_r    <= inst_cache_addr;
              mem_req_r <= 1'b1;
              state_r   <= ADDR;
            end else begin
              state_r <= IDLE;
            end
          end
          // Request is never withdrawn here; a same-cycle data_ok is ignored.
          ADDR: begin
            if (mem_addr_ok) begin
              mem_req_r <= 1'b0;
              state_r   <= DATA;
            end else begin
              state_r <= ADDR;
            end
          end
          DATA: begin
            if (mem_data_ok) begin
              if (hit_s) begin
                rdata_r <= mem_rdata;
                dok_r   <= 1'b1;
                state_r <= DONE;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              state_r <= DATA;
            end
          end
          // No request sampled here: the cache only hits after its line write.
          DONE: begin
            state_r <= IDLE;
          end
          default: begin
            mem_req_r <= 1'b0;
            state_r   <= IDLE;
          end
        endcase
      end
    end
  end

  assign inst_cache_rdata = rdata_r;
  assign inst_cache_dok   = dok_r;
  assign inst_cache_err   = err_r;
  assign mem_req          = mem_req_r;
  assign mem_addr         = addr_r;

endmodule

// File: tb/tb_inst_refill_bridge.sv
// Bench for inst_refill_bridge: each transaction is planned up front
// (address, data, addr_ok delay, data_ok delay, stale kind), memory responses
// are driven open-loop from that plan, and expected outputs follow from the
// cycle arithmetic of the plan.
module tb_inst_refill_bridge;

  localparam int TO = 12;

  logic        clk;
  logic        resetn;
  logic        inst_cache_req;
  logic [31:0] inst_cache_addr;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;
  logic        inst_cache_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'd0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] addr2;
    logic [31:0] data;
    int d1;
    int d2;
    int stale;
    int gap;
    int exp_dok;
  } vec_t;

  vec_t tbl [6];

  inst_refill_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_cache_req   (inst_cache_req),
    .inst_cache_addr  (inst_cache_addr),
    .inst_cache_rdata (inst_cache_rdata),
    .inst_cache_dok   (inst_cache_dok),
    .inst_cache_err   (inst_cache_err),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_addr_ok      (mem_addr_ok),
    .mem_data_ok      (mem_data_ok),
    .mem_rdata        (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One planned miss. Cycle 0 is the IDLE cycle where req is first sampled.
  // stale: 0 none, 1 address changes in DATA, 2 req dropped in DATA.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] a2, input logic [31:0] d,
                         input int d1, input int d2, input int stale, input int exp_dok);
    int len;
    len = (stale != 0) ? (3 + d1 + d2) : (4 + d1 + d2);
    for (int c = 0; c < len; c++) begin
      chk("mem_req", {31'd0, mem_req}, {31'd0, (c >= 1 && c <= 1 + d1)});
      if (c >= 1) chk("mem_addr", mem_addr, a);
      chk("dok", {31'd0, inst_cache_dok}, {31'd0, (c == exp_dok)});
      if (c == exp_dok) model_rdata = d;
      chk("rdata", inst_cache_rdata, model_rdata);
      chk("err", {31'd0, inst_cache_err}, 32'd0);
      inst_cache_req  = !(stale == 2 && c >= 2 + d1);
      inst_cache_addr = (stale == 1 && c >= 2 + d1) ? a2 : a;
      if (c >= 1 && c <= 1 + d1) mem_addr_ok = (c == 1 + d1);
      else mem_addr_ok = 1'($urandom_range(0, 1));
      if (c >= 2 + d1 && c <= 2 + d1 + d2) mem_data_ok = (c == 2 + d1 + d2);
      else mem_data_ok = 1'($urandom_range(0, 1));
      mem_rdata = (c == 2 + d1 + d2) ? d : $urandom;
      step();
    end
  endtask

  // Idle gap: no request, random ignored acks.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
      chk("idle_dok", {31'd0, inst_cache_dok}, 32'd0);
      chk("idle_rdata", inst_cache_rdata, model_rdata);
      inst_cache_req = 1'b0;
      inst_cache_addr = $urandom;
      mem_addr_ok = 1'($urandom_range(0, 1));
      mem_data_ok = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step();
    end
  endtask

  initial begin
    tbl[0] = '{32'hBFC00000, 32'h0,      32'h3C08BFC0, 0, 0, 0, 0, 3};
    tbl[1] = '{32'h80001000, 32'h0,      32'hDEADBEEF, 3, 3, 0, 1, 9};
    tbl[2] = '{32'h00001000, 32'h2000,   32'h11111111, 0, 1, 1, 0, -1};
    tbl[3] = '{32'h00002000, 32'h0,      32'h22222222, 0, 0, 0, 0, 3};
    tbl[4] = '{32'h00000000, 32'h0,      32'hA5A5A5A5, 0, 0, 0, 0, 3};
    tbl[5] = '{32'h00000004, 32'h0,      32'h5A5A5A5A, 0, 0, 0, 2, 3};

    resetn = 1'b0;
    inst_cache_req = 1'b0;
    inst_cache_addr = 32'd0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata = 32'd0;
    step();
    step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata", inst_cache_rdata, 32'd0);
    chk("rst_dok", {31'd0, inst_cache_dok}, 32'd0);
    chk("rst_err", {31'd0, inst_cache_err}, 32'd0);
    resetn = 1'b1;
    step();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].addr, tbl[i].addr2, tbl[i].data, tbl[i].d1, tbl[i].d2,
              tbl[i].stale, tbl[i].exp_dok);
      idle(tbl[i].gap);
    end

    // Reset while in DATA, then a late data_ok must be ignored.
    inst_cache_req = 1'b1;
    inst_cache_addr = 32'h12345678;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    step();
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    resetn = 1'b0;
    inst_cache_req = 1'b0;
    step();
    model_rdata = 32'd0;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_rdata", inst_cache_rdata, 32'd0);
    chk("midrst_dok", {31'd0, inst_cache_dok}, 32'd0);
    chk("midrst_err", {31'd0, inst_cache_err}, 32'd0);
    resetn = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    mem_data_ok = 1'b0;
    chk("late_data_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("late_data_dok", {31'd0, inst_cache_dok}, 32'd0);
    chk("late_data_rdata", inst_cache_rdata, 32'd0);

`ifdef INST_REFILL_TIMEOUT_EN
    // Give rdata a nonzero value first so the timeout clear is visible.
    run_txn(32'h00000040, 32'h0, 32'h0BADCAFE, 0, 0, 0, 3);
    for (int c = 0; c <= TO + 1; c++) begin
      chk("to_mem_req", {31'd0, mem_req}, {31'd0, (c >= 1 && c <= TO)});
      chk("to_err", {31'd0, inst_cache_err}, {31'd0, (c == TO + 1)});
      chk("to_dok", {31'd0, inst_cache_dok}, 32'd0);
      if (c == TO + 1) begin
        model_rdata = 32'd0;
        chk("to_rdata", inst_cache_rdata, 32'd0);
      end
      inst_cache_req = (c <= TO);
      inst_cache_addr = 32'h00000080;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      step();
    end
    chk("to_err_clear", {31'd0, inst_cache_err}, 32'd0);
`endif

    // Randomized misses with delays kept well below the watchdog limit.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int d1, d2, st;
      a  = $urandom & 32'hFFFF_FFFC;
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run_txn(a, a ^ 32'h0000_0010, $urandom, d1, d2, st, (st != 0) ? -1 : (3 + d1 + d2));
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
